// File: rtl/reg_file_param.sv
// Parametrised integer register file: one write port, two combinational read ports,
// optional hardwired x0 and write bypass, and a one-entry-per-cycle clear engine.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  input  logic                  CLEAR,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  BUSY,
  output logic                  WRDROP
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

  typedef enum logic {ST_CLR, ST_RDY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    wrdrop_q, wrdrop_d;
  logic                    busy;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_CLR;
      ptr_q    <= '0;
      wrdrop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wrdrop_q <= wrdrop_d;
    end
  end

  // The pointer parks at the last entry instead of wrapping; RDY is entered there.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLR: begin
        if (CLEAR) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_RDY;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        if (CLEAR) begin
          state_d = ST_CLR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // Single write port shared by reset, the clear engine and normal writes.
  always_comb begin
    busy      = (state_q == ST_CLR);
    wrdrop_d  = WRITE && (busy || CLEAR);
    mem_we    = 1'b0;
    mem_waddr = INADDRESS;
    mem_wdata = IN;
    if (RESET) begin
      mem_we    = 1'b1;
      mem_waddr = '0;
      mem_wdata = '0;
    end else if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (WRITE && !CLEAR && !(ZERO_REG != 0 && INADDRESS == '0)) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    if (busy) begin
      data = '0;
    end else if (ZERO_REG != 0 && addr == '0) begin
      data = '0;
    end else if (BYPASS != 0 && WRITE && !CLEAR && addr == INADDRESS) begin
      data = IN;
    end else begin
      data = mem[addr];
    end
    return data;
  endfunction

  assign OUT1   = read_port(OUT1ADDRESS);
  assign OUT2   = read_port(OUT2ADDRESS);
  assign BUSY   = busy;
  assign WRDROP = wrdrop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised and directed bench for reg_file_param; two instances (x0/bypass on and off)
// share stimulus and are compared against an array-based reference model.
module tb_reg_file_param;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        clr;
  logic [31:0] out1_a, out2_a, out1_b, out2_b;
  logic        busy_a, busy_b, wrdrop_a, wrdrop_b;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  int          busy_left;
  logic        wrdrop_m;

  reg_file_param dut_a (
    .CLK(clk), .RESET(rst), .WRITE(we), .INADDRESS(waddr), .IN(wdata),
    .OUT1ADDRESS(raddr1), .OUT2ADDRESS(raddr2), .CLEAR(clr),
    .OUT1(out1_a), .OUT2(out2_a), .BUSY(busy_a), .WRDROP(wrdrop_a)
  );

  reg_file_param #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(clk), .RESET(rst), .WRITE(we), .INADDRESS(waddr), .IN(wdata),
    .OUT1ADDRESS(raddr1), .OUT2ADDRESS(raddr2), .CLEAR(clr),
    .OUT1(out1_b), .OUT2(out2_b), .BUSY(busy_b), .WRDROP(wrdrop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", tag, txn, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit zr, input bit byp, input bit alt,
                                         input logic [4:0] a, input bit w, input bit c,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (busy_left != 0)            return 32'h0;
    if (zr && a == 5'd0)           return 32'h0;
    if (byp && w && !c && a == wa) return wd;
    return alt ? mem_b[a] : mem_a[a];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rst = r; clr = c; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    #1;
    txn++;
    chk("out1_a", out1_a, exp_rd(1'b1, 1'b1, 1'b0, a1, w, c, wa, wd));
    chk("out2_a", out2_a, exp_rd(1'b1, 1'b1, 1'b0, a2, w, c, wa, wd));
    chk("out1_b", out1_b, exp_rd(1'b0, 1'b0, 1'b1, a1, w, c, wa, wd));
    chk("out2_b", out2_b, exp_rd(1'b0, 1'b0, 1'b1, a2, w, c, wa, wd));
    chk("busy_a", {31'b0, busy_a}, {31'b0, busy_left != 0});
    chk("busy_b", {31'b0, busy_b}, {31'b0, busy_left != 0});
    chk("wrdrop_a", {31'b0, wrdrop_a}, {31'b0, wrdrop_m});
    chk("wrdrop_b", {31'b0, wrdrop_b}, {31'b0, wrdrop_m});
    $display("txn %0d rst=%0b clr=%0b we=%0b wa=%0d wd=%h a1=%0d a2=%0d out1=%h/%h out2=%h/%h busy=%0b wrdrop=%0b",
             txn, r, c, w, wa, wd, a1, a2, out1_a, out1_b, out2_a, out2_b, busy_a, wrdrop_a);
    @(posedge clk);
    // Reference: a clear empties the whole array at once; BUSY masks the gradual sweep.
    if (r) begin
      busy_left = DEPTH;
      wrdrop_m  = 1'b0;
      zero_model();
    end else begin
      wrdrop_m = w && (busy_left != 0 || c);
      if (busy_left != 0) begin
        busy_left = c ? DEPTH : busy_left - 1;
      end else if (c) begin
        busy_left = DEPTH;
        zero_model();
      end else if (w) begin
        if (wa != 5'd0) mem_a[wa] = wd;
        mem_b[wa] = wd;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom), 5'($urandom));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i += 2)
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    @(posedge clk);
    busy_left = DEPTH;
    wrdrop_m  = 1'b0;
    zero_model();

    // Reset sequence and exact clear length
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    idle(DEPTH + 2);
    read_all();

    // Basic write/read
    step(1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd1, 5'd2);
    step(1'b0, 1'b0, 1'b1, 5'd31, 32'h12345678, 5'd1, 5'd2);
    step(1'b0, 1'b0, 1'b0, 5'd0,  32'h0, 5'd5, 5'd31);
    step(1'b0, 1'b0, 1'b0, 5'd0,  32'h0, 5'd5, 5'd5);

    // Zero register
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Bypass
    step(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7);
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Clear and drop
    for (int i = 1; i < DEPTH; i++)
      step(1'b0, 1'b0, 1'b1, 5'(i), $urandom | 32'h1, 5'(i), 5'(i - 1));
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
    step(1'b0, 1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3);
    idle(DEPTH + 1);
    read_all();

    // Reset mid-clear
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    idle(10);
    step(1'b1, 1'b0, 1'b1, 5'd4, 32'h11111111, 5'd4, 5'd4);
    idle(DEPTH + 2);
    read_all();

    // Simultaneous reset and clear, then clear requested while already clearing
    step(1'b1, 1'b1, 1'b1, 5'd6, 32'h22222222, 5'd6, 5'd6);
    idle(5);
    step(1'b0, 1'b1, 1'b1, 5'd6, 32'h33333333, 5'd6, 5'd6);
    idle(DEPTH + 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
           5'($urandom), $urandom,
           ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
